xpmwrap_spram_req_ctrl: RTL and testbench

//  Requester-side controller driving one xpmwrap_spram_byte_write port. Converts valid/ready

---
 rtl/xpmwrap_spram_req_ctrl_pkg.sv | 20 ++
 rtl/xpmwrap_spram_req_ctrl_if.sv | 28 ++
 rtl/xpmwrap_rsp_fifo.sv | 71 +++++++
 rtl/xpmwrap_spram_req_ctrl.sv | 98 +++++++++
 tb/tb_xpmwrap_spram_req_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xpmwrap_spram_req_ctrl_pkg.sv
// Shared types and helpers for the SPRAM requester controller.
// Holds default widths, the request bundle and a count-width helper.
package xpmwrap_pkg;

  localparam int PKG_AW = 6;
  localparam int PKG_DW = 32;
  localparam int PKG_NB = 4;

  typedef struct packed {
    logic [PKG_NB-1:0] we;
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] wdata;
  } req_t;

  // Bits needed to hold values 0..n inclusive, never below 1.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xpmwrap_spram_req_ctrl_if.sv
// Request/response handshake bundle between a client and the controller.
// master = client side, slave = controller side.
interface xpmwrap_spram_req_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int NB = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [NB-1:0] req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/xpmwrap_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO for read responses.
// Ports: clk_i/rst_i, push_i/din_i, pop_i/dout_o, empty_o, count_o.
module xpmwrap_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];

  always_comb begin
    wp_d  = push_i ? nxt(wp_q) : wp_q;
    rp_d  = pop_i  ? nxt(rp_q) : rp_q;
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  a_no_ovf: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push_i && full));

  a_no_udf: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(pop_i && empty_o));

endmodule

// File: rtl/xpmwrap_spram_req_ctrl.sv
// Requester-side controller for one byte-write SPRAM port with latency absorb.
// Ports: clka/rsta, bus (req/rsp handshakes), rd_pending credits, mem_* RAM port.
module xpmwrap_spram_req_ctrl
  import xpmwrap_pkg::*;
#(
  parameter  int ADDR_WIDTH   = 6,
  parameter  int DATA_WIDTH   = 32,
  parameter  int BYTE_WIDTH   = 8,
  parameter  int READ_LATENCY = 2,
  parameter  int RSP_DEPTH    = 4,
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH,
  localparam int CW     = cnt_w(RSP_DEPTH)
) (
  input  logic                  clka,
  input  logic                  rsta,
  xpmwrap_spram_req_ctrl_if.slave bus,
  output logic [CW-1:0]         rd_pending,
  output logic                  mem_ena,
  output logic [NBYTES-1:0]     mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  output logic                  mem_regcea,
  output logic                  mem_rsta,
  input  logic [DATA_WIDTH-1:0] mem_douta
);

  if (RSP_DEPTH < READ_LATENCY + 1) begin : g_depth_chk
    $error("RSP_DEPTH must be >= READ_LATENCY+1");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_lat_chk
    $error("READ_LATENCY must be 1..4");
  end

  logic                    acc, rd_acc, cap, pop;
  logic                    empty;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           fcnt;

  // Credits cover in-flight plus buffered reads, so the FIFO can't overflow.
  assign bus.req_ready = !rsta && (cnt_q < CW'(RSP_DEPTH));
  assign acc    = bus.req_valid && bus.req_ready;
  assign rd_acc = acc && (bus.req_we == '0);

  assign mem_ena    = acc;
  assign mem_wea    = acc ? bus.req_we : '0;
  assign mem_addra  = bus.req_addr;
  assign mem_dina   = bus.req_wdata;
  assign mem_regcea = 1'b1;
  assign mem_rsta   = rsta;

  // Valid token emerges in the cycle the RAM presents read data.
  assign vld_d = READ_LATENCY'({vld_q, rd_acc});
  assign cap   = vld_q[READ_LATENCY-1];

  assign bus.rsp_valid = !rsta && !empty;
  assign pop = bus.rsp_valid && bus.rsp_ready;
  assign rd_pending = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({rd_acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  xpmwrap_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clka),
    .rst_i   (rsta),
    .push_i  (cap),
    .din_i   (mem_douta),
    .pop_i   (pop),
    .dout_o  (bus.rsp_rdata),
    .empty_o (empty),
    .count_o (fcnt)
  );

  a_credit: assert property (
    @(posedge clka) disable iff (rsta)
    fcnt <= cnt_q);

endmodule

// File: tb/tb_xpmwrap_spram_req_ctrl.sv
// Bench for xpmwrap_spram_req_ctrl with a behavioural read-first SPRAM.
// Table vectors for basic cycles, then directed/random sequences vs a model.
module tb_xpmwrap_spram_req_ctrl;
  import xpmwrap_pkg::*;

  logic        clka;
  logic        rsta;
  logic [2:0]  rd_pending;
  logic        mem_ena;
  logic [3:0]  mem_wea;
  logic [5:0]  mem_addra;
  logic [31:0] mem_dina;
  logic        mem_regcea;
  logic        mem_rsta;
  logic [31:0] mem_douta;

  xpmwrap_spram_req_ctrl_if #(.AW(6), .DW(32), .NB(4)) bus ();

  xpmwrap_spram_req_ctrl dut (
    .clka       (clka),
    .rsta       (rsta),
    .bus        (bus),
    .rd_pending (rd_pending),
    .mem_ena    (mem_ena),
    .mem_wea    (mem_wea),
    .mem_addra  (mem_addra),
    .mem_dina   (mem_dina),
    .mem_regcea (mem_regcea),
    .mem_rsta   (mem_rsta),
    .mem_douta  (mem_douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Read-first RAM, two-cycle read latency.
  logic [31:0] ram [64];
  logic [31:0] rd1;
  always @(posedge clka) begin
    if (mem_ena) begin
      rd1 <= ram[mem_addra];
      for (int b = 0; b < 4; b++)
        if (mem_wea[b]) ram[mem_addra][b*8 +: 8] <= mem_dina[b*8 +: 8];
    end
    if (mem_rsta) mem_douta <= '0;
    else if (mem_regcea) mem_douta <= rd1;
  end

  int n_vec = 0;
  int n_bad = 0;
  int n_rsp = 0;
  bit acc_seen;
  logic [31:0] shadow [64];
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_accept(input req_t r);
    if (r.we == '0) exp_q.push_back(shadow[r.addr]);
    else
      for (int b = 0; b < 4; b++)
        if (r.we[b]) shadow[r.addr][b*8 +: 8] = r.wdata[b*8 +: 8];
  endtask

  task automatic model_rsp();
    n_rsp++;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_unexpected: got %h want none", bus.rsp_rdata);
    end else begin
      chk("rsp_data", bus.rsp_rdata, exp_q.pop_front());
    end
  endtask

  // Inputs are set just after a negedge; evaluate handshakes, advance.
  task automatic tick();
    req_t r;
    #1;
    acc_seen = bus.req_valid && bus.req_ready;
    if (acc_seen) begin
      r.we = bus.req_we;
      r.addr = bus.req_addr;
      r.wdata = bus.req_wdata;
      model_accept(r);
    end
    if (bus.rsp_valid && bus.rsp_ready) model_rsp();
    @(negedge clka);
  endtask

  task automatic drive(input logic v, input logic [3:0] we,
                       input logic [5:0] a, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  we;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic        rr;
    logic        e_rdy;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [2:0]  e_pend;
    logic        e_ena;
  } vec_t;

  vec_t tv [20];
  int   cnt0;
  int   acc_n;

  initial begin
    tv[0]  = '{1, 0, 4'h0, 6'h00, 32'h0,        1, 0, 0, 32'h0,        0, 0};
    tv[1]  = '{0, 1, 4'hF, 6'h05, 32'hDEADBEEF, 1, 1, 0, 32'h0,        0, 1};
    tv[2]  = '{0, 1, 4'h0, 6'h05, 32'h0,        1, 1, 0, 32'h0,        0, 1};
    tv[3]  = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 0, 32'h0,        1, 0};
    tv[4]  = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 0, 32'h0,        1, 0};
    tv[5]  = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 1, 32'hDEADBEEF, 1, 0};
    tv[6]  = '{0, 1, 4'h1, 6'h05, 32'h000000AA, 1, 1, 0, 32'h0,        0, 1};
    tv[7]  = '{0, 1, 4'h0, 6'h05, 32'h0,        1, 1, 0, 32'h0,        0, 1};
    tv[8]  = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 0, 32'h0,        1, 0};
    tv[9]  = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 0, 32'h0,        1, 0};
    tv[10] = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 1, 32'hDEADBEAA, 1, 0};
    tv[11] = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 0, 32'h0,        0, 0};
    tv[12] = '{0, 1, 4'hF, 6'h07, 32'h11111111, 1, 1, 0, 32'h0,        0, 1};
    tv[13] = '{0, 1, 4'h0, 6'h07, 32'h0,        1, 1, 0, 32'h0,        0, 1};
    tv[14] = '{0, 1, 4'hF, 6'h07, 32'h22222222, 1, 1, 0, 32'h0,        1, 1};
    tv[15] = '{0, 1, 4'h0, 6'h07, 32'h0,        1, 1, 0, 32'h0,        1, 1};
    tv[16] = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 1, 32'h11111111, 2, 0};
    tv[17] = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 0, 32'h0,        1, 0};
    tv[18] = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 1, 32'h22222222, 1, 0};
    tv[19] = '{0, 0, 4'h0, 6'h00, 32'h0,        1, 1, 0, 32'h0,        0, 0};

    rsta = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(0, 4'h0, 6'h0, 32'h0);
    repeat (2) @(negedge clka);

    for (int i = 0; i < 20; i++) begin
      rsta = tv[i].rst;
      bus.rsp_ready = tv[i].rr;
      drive(tv[i].vld, tv[i].we, tv[i].addr, tv[i].wd);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].e_rdy));
      chk($sformatf("v%0d_rvalid", i), 32'(bus.rsp_valid), 32'(tv[i].e_rv));
      chk($sformatf("v%0d_pend", i), 32'(rd_pending), 32'(tv[i].e_pend));
      chk($sformatf("v%0d_ena", i), 32'(mem_ena), 32'(tv[i].e_ena));
      if (tv[i].e_ena)
        chk($sformatf("v%0d_wea", i), 32'(mem_wea), 32'(tv[i].we));
      if (tv[i].e_rv)
        chk($sformatf("v%0d_rdata", i), bus.rsp_rdata, tv[i].e_rd);
      @(negedge clka);
    end

    // Fill every address with a known pattern.
    for (int a = 0; a < 64; a++) begin
      drive(1, 4'hF, 6'(a), 32'h5A000000 + 32'(a) * 32'h00010203);
      tick();
    end
    drive(0, 4'h0, 6'h0, 32'h0);

    // Backpressure: six reads with rsp_ready low.
    bus.rsp_ready = 1'b0;
    acc_n = 0;
    cnt0 = n_rsp;
    for (int k = 0; k < 8; k++) begin
      drive(acc_n < 6, 4'h0, 6'(acc_n), 32'h0);
      tick();
      if (acc_seen) acc_n++;
    end
    #1;
    chk("bp_accepts", 32'(acc_n), 32'd4);
    chk("bp_pend", 32'(rd_pending), 32'd4);
    chk("bp_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (acc_n == 6 && exp_q.size() == 0) break;
      drive(acc_n < 6, 4'h0, 6'(acc_n), 32'h0);
      tick();
      if (acc_seen) acc_n++;
    end
    drive(0, 4'h0, 6'h0, 32'h0);
    #1;
    chk("bp_rsp_cnt", 32'(n_rsp - cnt0), 32'd6);
    chk("bp_pend_end", 32'(rd_pending), 32'd0);
    @(negedge clka);

    // Streaming reads at full rate.
    cnt0 = n_rsp;
    for (int k = 0; k < 64; k++) begin
      drive(1, 4'h0, 6'(k), 32'h0);
      tick();
      chk("stream_acc", 32'(acc_seen), 32'd1);
    end
    drive(0, 4'h0, 6'h0, 32'h0);
    repeat (3) tick();
    chk("stream_rsp_cnt", 32'(n_rsp - cnt0), 32'd64);

    // Reset with two reads in flight and one buffered.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'h0, 6'(10 + k), 32'h0);
      tick();
    end
    drive(0, 4'h0, 6'h0, 32'h0);
    #1;
    chk("rst_pre_rv", 32'(bus.rsp_valid), 32'd1);
    chk("rst_pre_pend", 32'(rd_pending), 32'd3);
    rsta = 1'b1;
    @(negedge clka);
    rsta = 1'b0;
    #1;
    chk("rst_post_rv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_post_pend", 32'(rd_pending), 32'd0);
    chk("rst_post_rdy", 32'(bus.req_ready), 32'd1);
    exp_q.delete();
    bus.rsp_ready = 1'b1;
    cnt0 = n_rsp;
    drive(1, 4'hF, 6'h3F, 32'hFEEDF00D);
    tick();
    drive(1, 4'h0, 6'h3F, 32'h0);
    tick();
    drive(0, 4'h0, 6'h0, 32'h0);
    repeat (8) tick();
    chk("rst_rsp_cnt", 32'(n_rsp - cnt0), 32'd1);

    // Random backpressure with mixed traffic.
    for (int k = 0; k < 300; k++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0)
        drive($urandom_range(0, 9) < 7, 4'h0,
              6'($urandom_range(0, 7)), 32'h0);
      else
        drive($urandom_range(0, 9) < 7, 4'($urandom_range(1, 15)),
              6'($urandom_range(0, 7)), $urandom);
      tick();
    end
    drive(0, 4'h0, 6'h0, 32'h0);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    #1;
    chk("rand_pend", 32'(rd_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
